// File: rtl/axi_rw_arbiter_pkg.sv
// axi_rw_arbiter_pkg: shared constants, FSM encoding and round-robin helpers for the axi_rw arbiter.
package axi_rw_arbiter_pkg;

    typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_t;

    typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2, SIZE_D = 2'd3} size_t;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

    localparam logic [3:0] ARB_ID_ICACHE  = 4'b0001;
    localparam logic [3:0] ARB_ID_DCACHE  = 4'b0010;
    localparam logic [3:0] ARB_ID_UNCACHE = 4'b0100;

    localparam logic [1:0] ARB_LAST_RESET = 2'd2;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [3:0] arb_id(input logic [1:0] idx);
        return (idx == 2'd0) ? ARB_ID_ICACHE : (idx == 2'd1) ? ARB_ID_DCACHE : ARB_ID_UNCACHE;
    endfunction

endpackage

// File: rtl/axi_rw_arbiter_rr_pick3.sv
// rr_pick3: combinational three-way round-robin picker, searching from last+1 upwards with wrap.
module rr_pick3
    import axi_rw_arbiter_pkg::*;
(
    input  logic [2:0] valid,
    input  logic [1:0] last,
    output logic [2:0] grant,
    output logic [1:0] index,
    output logic       any
);

    logic [3:0] v;
    logic [1:0] s0, s1, s2;

    always_comb begin
        v     = {1'b0, valid};
        s0    = rr_next(last);
        s1    = rr_next(s0);
        s2    = rr_next(s1);
        index = v[s0] ? s0 : v[s1] ? s1 : s2;
        any   = |valid;
        grant = any ? 3'(3'd1 << index) : 3'd0;
    end

endmodule

// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: shares the axi_rw port between icache, dcache and uncached path with round-robin
// grants, latching the winner for the whole transaction and routing completion back by latched grant.
module axi_rw_arbiter
    import axi_rw_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_valid_i,
    output logic                  ic_ready_o,
    input  logic                  ic_req_i,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    input  logic [1:0]            ic_size_i,
    input  logic [DATA_WIDTH-1:0] ic_wdata_i,
    input  logic [7:0]            ic_wmask_i,
    output logic [DATA_WIDTH-1:0] ic_rdata_o,
    output logic [1:0]            ic_resp_o,
    input  logic                  dc_valid_i,
    output logic                  dc_ready_o,
    input  logic                  dc_req_i,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic [1:0]            dc_size_i,
    input  logic [DATA_WIDTH-1:0] dc_wdata_i,
    input  logic [7:0]            dc_wmask_i,
    output logic [DATA_WIDTH-1:0] dc_rdata_o,
    output logic [1:0]            dc_resp_o,
    input  logic                  uc_valid_i,
    output logic                  uc_ready_o,
    input  logic                  uc_req_i,
    input  logic [ADDR_WIDTH-1:0] uc_addr_i,
    input  logic [1:0]            uc_size_i,
    input  logic [DATA_WIDTH-1:0] uc_wdata_i,
    input  logic [7:0]            uc_wmask_i,
    output logic [DATA_WIDTH-1:0] uc_rdata_o,
    output logic [1:0]            uc_resp_o,
    output logic                  rw_valid_o,
    input  logic                  rw_ready_i,
    output logic                  rw_req_o,
    output logic [ADDR_WIDTH-1:0] rw_addr_o,
    output logic [1:0]            rw_size_o,
    output logic [DATA_WIDTH-1:0] rw_wdata_o,
    output logic [7:0]            rw_wmask_o,
    output logic [ID_WIDTH-1:0]   rw_id_o,
    input  logic [DATA_WIDTH-1:0] rw_rdata_i,
    input  logic [1:0]            rw_resp_i
);

    arb_state_t            state;
    logic [1:0]            last;
    logic [1:0]            gidx;
    logic [2:0]            pick_grant;
    logic [1:0]            pick_index;
    logic                  pick_any;
    logic                  sel_req;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [7:0]            sel_wmask;
    logic                  done;

    rr_pick3 u_pick (
        .valid (({uc_valid_i, dc_valid_i, ic_valid_i})),
        .last  (last),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    // ic is read-only, so its req input is masked to a read
    always_comb begin
        sel_req   = pick_grant[0] ? (1'(REQ_READ) & ic_req_i) : pick_grant[1] ? dc_req_i : uc_req_i;
        sel_addr  = pick_grant[0] ? ic_addr_i  : pick_grant[1] ? dc_addr_i  : uc_addr_i;
        sel_size  = pick_grant[0] ? ic_size_i  : pick_grant[1] ? dc_size_i  : uc_size_i;
        sel_wdata = pick_grant[0] ? ic_wdata_i : pick_grant[1] ? dc_wdata_i : uc_wdata_i;
        sel_wmask = pick_grant[0] ? ic_wmask_i : pick_grant[1] ? dc_wmask_i : uc_wmask_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last       <= ARB_LAST_RESET;
            gidx       <= 2'd0;
            rw_req_o   <= 1'b0;
            rw_addr_o  <= '0;
            rw_size_o  <= 2'd0;
            rw_wdata_o <= '0;
            rw_wmask_o <= 8'd0;
            rw_id_o    <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_any) begin
                state      <= ARB_BUSY;
                last       <= pick_index;
                gidx       <= pick_index;
                rw_req_o   <= sel_req;
                rw_addr_o  <= sel_addr;
                rw_size_o  <= sel_size;
                rw_wdata_o <= sel_wdata;
                rw_wmask_o <= sel_wmask;
                rw_id_o    <= ID_WIDTH'(arb_id(pick_index));
            end
        end else if (rw_ready_i) begin
            state <= ARB_IDLE;
        end
    end

    // valid is masked in the completion cycle so axi_rw sees a clean gap before the next request
    always_comb begin
        done       = (state == ARB_BUSY) & rw_ready_i;
        rw_valid_o = (state == ARB_BUSY) & ~rw_ready_i;
        ic_ready_o = done & (gidx == 2'd0);
        dc_ready_o = done & (gidx == 2'd1);
        uc_ready_o = done & (gidx == 2'd2);
        ic_rdata_o = ic_ready_o ? rw_rdata_i : '0;
        dc_rdata_o = dc_ready_o ? rw_rdata_i : '0;
        uc_rdata_o = uc_ready_o ? rw_rdata_i : '0;
        ic_resp_o  = ic_ready_o ? rw_resp_i : 2'd0;
        dc_resp_o  = dc_ready_o ? rw_resp_i : 2'd0;
        uc_resp_o  = uc_ready_o ? rw_resp_i : 2'd0;
    end

endmodule

// File: doc/axi_rw_arbiter.md
# axi_rw_arbiter

Three-way arbiter that shares the single `axi_rw` transaction port between the instruction cache, data cache and uncached load/store path. It selects one requester with round-robin priority and latches that request for the whole transaction. It routes the completion pulse, read data and response back to the granted requester only. It sits between the cache/LSU layer and `axi_rw`, and guarantees the one-idle-cycle gap `axi_rw` needs between back-to-back transactions.

## Interface
Parameters:
- `DATA_WIDTH`, 64: request/read/write data width.
- `ADDR_WIDTH`, 64: request address width.
- `ID_WIDTH`, 4: one-hot requester ID width.

Ports, in order clock, reset, requesters, then downstream:
- `clock`  in  1  clock
- `reset`  in  1  synchronous, active-high
- Per requester, N = `ic`, `dc`, `uc`:
  - `N_valid_i`  in  1  request pending
  - `N_ready_o`  out  1  one-cycle completion pulse
  - `N_req_i`  in  1  0 = read, 1 = write; `ic_req_i` is ignored and `ic` is always a read
  - `N_addr_i`  in  ADDR_WIDTH  byte address
  - `N_size_i`  in  2  `SIZE_B/H/W/D`
  - `N_wdata_i`  in  DATA_WIDTH  write data
  - `N_wmask_i`  in  8  write strobe
  - `N_rdata_o`  out  DATA_WIDTH  read data, valid while `N_ready_o`
  - `N_resp_o`  out  2  AXI response, valid while `N_ready_o`
- Downstream to `axi_rw`:
  - `rw_valid_o`  out  1
  - `rw_ready_i`  in  1
  - `rw_req_o`  out  1
  - `rw_addr_o`  out  ADDR_WIDTH
  - `rw_size_o`  out  2
  - `rw_wdata_o`  out  DATA_WIDTH
  - `rw_wmask_o`  out  8
  - `rw_id_o`  out  ID_WIDTH  one-hot: ic = 4'b0001, dc = 4'b0010, uc = 4'b0100
  - `rw_rdata_i`  in  DATA_WIDTH
  - `rw_resp_i`  in  2

## Operation
- FSM states:
  - IDLE: if any `N_valid_i` is high, pick a winner, latch its req/addr/size/wdata/wmask, latch the grant index, update the last-grant pointer, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: wait for `rw_ready_i`. When it arrives, return to IDLE.
- Round-robin selection:
  - Index order is ic = 0, dc = 1, uc = 2.
  - The search starts at (last + 1) mod 3.
  - `last` resets to 2, so ic wins the first tie.
- Downstream drive:
  - `rw_valid_o` = (state == BUSY) & ~`rw_ready_i`. It is masked in the completion cycle so `axi_rw` does not restart from IDLE.
  - All `rw_*` request outputs come from the latched registers and stay stable for the whole of BUSY.
- Completion routing:
  - In the cycle `rw_ready_i` is high while in BUSY, assert `N_ready_o` for the latched grant only.
  - Drive `N_rdata_o` = `rw_rdata_i` and `N_resp_o` = `rw_resp_i` to the granted requester. Non-granted requesters get zero.
  - Routing uses the latched grant, never a returned ID; `axi_rw`'s returned ID is undefined on writes.
- Requester contract:
  - Hold `N_valid_i` and its fields stable until `N_ready_o`.
  - Deassert `N_valid_i` in the cycle after the pulse, or the arbiter treats it as a new request.
- `rw_ready_i` while in IDLE is ignored: no requester pulse, no state change.

## Timing
- Reset values: state IDLE, `last` = 2, all latched fields 0, `rw_valid_o` = 0, `rw_id_o` = 0, all `N_ready_o` = 0, all `N_rdata_o` and `N_resp_o` = 0.
- Grant latency: a request seen in IDLE at cycle t drives `rw_valid_o` high from cycle t+1.
- Completion: `N_ready_o` is combinational from `rw_ready_i`, so it appears in the same cycle.
- Minimum spacing: IDLE is occupied for at least one cycle after each completion, so `rw_valid_o` is low for at least two cycles (the completion cycle plus the IDLE cycle).
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting and are granted in rotation order.
- Reset mid-transaction: the FSM returns to IDLE immediately, no `N_ready_o` is emitted, and the latched fields are cleared. `axi_rw` shares the same reset.

## Structure
- Constants belong in `defines.v`:
  - `REQ_READ` / `REQ_WRITE`
  - `SIZE_B/H/W/D`
  - New `ARB_ID_ICACHE` 4'b0001, `ARB_ID_DCACHE` 4'b0010, `ARB_ID_UNCACHE` 4'b0100
  - FSM encodings `ARB_IDLE` / `ARB_BUSY`
- One sub-module, `rr_pick3`: combinational 3-input round-robin picker.
  - Inputs: valid[2:0], last[1:0].
  - Outputs: grant one-hot, index, any.

## Test plan
- Single ic read:
  - Stimulus: `ic_valid_i` with addr 0x8000_0000; downstream returns `rw_ready_i` with rdata 0x1122334455667788 after 5 cycles.
  - Required: `rw_id_o` = 0001, `rw_req_o` = 0, `ic_ready_o` pulses 1 cycle with that rdata, `dc_ready_o` and `uc_ready_o` stay 0.
- dc write:
  - Stimulus: `dc_valid_i` with req = 1, addr 0x8000_0010, wmask 0x0F, wdata 0xDEADBEEF; resp 2'b00.
  - Required: `rw_req_o` = 1, `rw_wmask_o` = 0x0F, `rw_id_o` = 0010, `dc_resp_o` = 0 with `dc_ready_o`.
- All three valid from reset, requesters drop valid after their pulse:
  - Required grant order ic, dc, uc.
  - `rw_valid_o` low in every completion cycle and the following cycle.
- Starvation/rotation:
  - Stimulus: ic and uc both held valid continuously, each re-requesting after its pulse.
  - Required: grants alternate ic, uc, ic, uc; dc is never granted.
- Boundary inputs:
  - Stable fields: `ic_addr_i` changes while ic is granted → `rw_addr_o` stays at the latched value.
  - Spurious ready: `rw_ready_i` asserted while IDLE → no `N_ready_o`.
  - Reset mid-operation: reset asserted during BUSY → next cycle all outputs are at reset values and the pending request is re-arbitrated afterwards.
